razr_round_sat: RTL

- Pipelined width-reduction stage for the single-carrier modulator datapath.
- Takes full-scale signed samples, rounds and arithmetic-right-shifts them by SHIFT bits, then saturates the result to OUT_W bits.
- Feeds the fixed-width slicing/DAC-facing stages that follow it.
- Uses a valid/ready handshake on both sides and keeps a saturation event counter for gain-tuning diagnostics.

---
 rtl/razr_round_sat.sv | 111 +++++++++++
 1 files changed

// File: rtl/razr_round_sat.sv
// razr_round_sat: two-stage width reduction for the modulator datapath.
// Each sample is rounded half-up, arithmetic-shifted right by SHIFT and
// clipped to OUT_W bits. Valid/ready on both sides, with a saturating
// count of clipped samples.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_data/valid/ready   upstream sample handshake (in_ready is combinational)
//   out_data/valid/ready  downstream sample handshake (registered outputs)
//   out_sat               current out_data was clipped (qualified by out_valid)
//   cnt_clr               synchronous clear of sat_cnt
//   sat_cnt               clipped samples transferred on the output
module razr_round_sat #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 12,
  parameter int unsigned SHIFT = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sat,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] sat_cnt
);

  localparam int unsigned SUM_W = IN_W + 1;
  localparam int unsigned SH_W  = IN_W + 1 - SHIFT;

  localparam logic [SUM_W-1:0] RND = SUM_W'(1) << (SHIFT - 1);
  // Output limits expressed at the shifted width, so they compare signed
  localparam logic signed [SH_W-1:0] SAT_MAX =
    {{(SH_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [SH_W-1:0] SAT_MIN = ~SAT_MAX;

  logic                    s1_v;
  logic [SUM_W-1:0]        s1_sum;
  logic                    s1_adv;
  logic                    s2_adv;
  logic signed [SH_W-1:0]  sh;
  logic [OUT_W-1:0]        sat_data;
  logic                    sat_flag;
  logic                    cnt_inc;

  // Pipeline advance: a stage moves when it is empty or its consumer moves
  always_comb begin
    s2_adv   = !out_valid || out_ready;
    s1_adv   = !s1_v || s2_adv;
    in_ready = s1_adv;
    cnt_inc  = out_valid && out_ready && out_sat;
  end

  // Shift the rounded sum and clip to the output range
  always_comb begin
    sh       = SH_W'($signed(s1_sum) >>> SHIFT);
    sat_data = OUT_W'(sh);
    sat_flag = 1'b0;
    if (sh > SAT_MAX) begin
      sat_data = OUT_W'(SAT_MAX);
      sat_flag = 1'b1;
    end else if (sh < SAT_MIN) begin
      sat_data = OUT_W'(SAT_MIN);
      sat_flag = 1'b1;
    end
  end

  // S1: sign-extend by one bit and add the half-LSB rounding constant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v   <= 1'b0;
      s1_sum <= '0;
    end else if (s1_adv) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_sum <= {in_data[IN_W-1], in_data} + RND;
      end
    end
  end

  // S2: registered outputs; data only reloads when S1 holds a sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_v;
      if (s1_v) begin
        out_data <= sat_data;
        out_sat  <= sat_flag;
      end
    end
  end

  // Saturation event counter: clear wins, sticks at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (cnt_clr) begin
      sat_cnt <= '0;
    end else if (cnt_inc && !(&sat_cnt)) begin
      sat_cnt <= sat_cnt + CNT_W'(1);
    end
  end

endmodule
